// File: rtl/replay_buffer_pkg.sv
// Shared types and helpers for the DLL replay buffer.
// Optional feature macro used by the top: REPLAY_NUM_EN (replay counter + retrain output).
package replay_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PURGE  = 2'd1,
      REPLAY = 2'd2
   } state_e;

   localparam logic [1:0] NONE_CODE = 2'b00;
   localparam logic [1:0] ACK_CODE  = 2'b01;
   localparam logic [1:0] NAK_CODE  = 2'b10;

   // True when a is at or before b in modulo-2^seq_w sequence space,
   // i.e. (b - a) mod 2^seq_w falls in the lower half of the number space.
   function automatic logic seq_le(input logic [31:0] a, input logic [31:0] b, input int seq_w);
      logic [31:0] mask;
      logic [31:0] diff;
      mask = (32'd1 << seq_w) - 32'd1;
      diff = (b - a) & mask;
      return (diff < (32'd1 << (seq_w - 1)));
   endfunction

endpackage

// File: rtl/replay_buffer_param_store.sv
// Entry storage for the replay buffer: DEPTH x W register array,
// one synchronous write port and one asynchronous read port.
module replay_store
   import replay_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 140
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Write port: store one {seq, tlp} entry per accepted write.
   // NOTE: the array has no reset; validity is tracked solely by the pointers in
   // the top, so clearing every slot would only add reset fan-out for no benefit.
   // NOTE: clocked state always uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/replay_buffer_param.sv
// DLL replay buffer: stores TLPs until ACKed, purges on ACK/NAK and replays
// all unacknowledged TLPs (oldest first) as DOUT_W beats on NAK or timeout.
// Optional feature macro: REPLAY_NUM_EN adds a 2-bit replay counter and the
// retrain output pulse on the fourth consecutive replay without progress.
module replay_buffer_param
   import replay_buffer_pkg::*;
#(
   parameter int DIN_W  = 128,
   parameter int DOUT_W = 16,
   parameter int DEPTH  = 8,
   parameter int SEQ_W  = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [DIN_W-1:0]  din,
   input  logic [SEQ_W-1:0]  seq,
   input  logic [1:0]        ack_nack,
   input  logic [SEQ_W-1:0]  ack_seq,
   input  logic              tim_out,
   input  logic              busy_n,
   output logic              ready,
   output logic [DOUT_W-1:0] dout,
   output logic              dout_vld,
   output logic              dout_sop,
   output logic              dout_eop,
`ifdef REPLAY_NUM_EN
   output logic              retrain,
`endif
   output logic              empty
);

   localparam int NB = DIN_W / DOUT_W;
   localparam int AW = $clog2(DEPTH);
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int EW = SEQ_W + DIN_W;

   typedef logic [AW:0] ptr_t;

   localparam ptr_t          PTR_ONE   = ptr_t'(1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

   state_e                state_q, state_d;
   ptr_t                  wr_ptr_q, wr_ptr_d;
   ptr_t                  rd_ptr_q, rd_ptr_d;
   ptr_t                  rp_q, rp_d;
   ptr_t                  rp_nxt;
   logic [BW-1:0]         beat_q, beat_d;
   logic [BW-1:0]         beat_sel;
   logic                  replay_q, replay_d;
   logic [1:0]            pend_q, pend_d;
   logic [SEQ_W-1:0]      pend_seq_q, pend_seq_d;
   logic [SEQ_W-1:0]      purge_seq_q, purge_seq_d;
   logic [DOUT_W-1:0]     dout_q, dout_d;
   logic                  vld_q, vld_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;

   logic                  full;
   logic                  empty_w;
   logic                  wr_en;
   logic                  cmd_vld;
   logic [AW-1:0]         rd_addr;
   logic [EW-1:0]         rd_entry;
   logic [SEQ_W-1:0]      head_seq;
   logic [NB-1:0][DOUT_W-1:0] rd_beats;

   assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty_w  = (wr_ptr_q == rd_ptr_q);
   assign ready    = !full && (state_q == IDLE);
   assign wr_en    = we && ready;
   assign cmd_vld  = (ack_nack == ACK_CODE) || (ack_nack == NAK_CODE);
   assign rd_addr  = (state_q == REPLAY) ? rp_q[AW-1:0] : rd_ptr_q[AW-1:0];
   assign head_seq = rd_entry[EW-1 -: SEQ_W];
   assign rd_beats = rd_entry[DIN_W-1:0];
   assign beat_sel = LAST_BEAT - beat_q;
   assign rp_nxt   = rp_q + PTR_ONE;

   replay_store #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_store (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata ({seq, din}),
      .raddr (rd_addr),
      .rdata (rd_entry)
   );

   // Next-state logic: FSM, pointers, pending ACK/NAK and replay beat generation.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      wr_ptr_d    = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rp_d        = rp_q;
      beat_d      = beat_q;
      replay_d    = replay_q;
      pend_d      = pend_q;
      pend_seq_d  = pend_seq_q;
      purge_seq_d = purge_seq_q;
      dout_d      = dout_q;
      vld_d       = 1'b0;
      sop_d       = sop_q;
      eop_d       = eop_q;

      // Outside IDLE the latest ACK/NAK is parked until the FSM returns to IDLE.
      if ((state_q != IDLE) && cmd_vld) begin
         pend_d     = ack_nack;
         pend_seq_d = ack_seq;
      end

      unique case (state_q)
         IDLE: begin
            pend_d = NONE_CODE;
            if (cmd_vld) begin
               state_d     = PURGE;
               replay_d    = (ack_nack == NAK_CODE);
               purge_seq_d = ack_seq;
            end else if (pend_q != NONE_CODE) begin
               state_d     = PURGE;
               replay_d    = (pend_q == NAK_CODE);
               purge_seq_d = pend_seq_q;
            end else if (tim_out && !empty_w) begin
               state_d = REPLAY;
               rp_d    = rd_ptr_q;
               beat_d  = '0;
            end
         end

         PURGE: begin
            if (!empty_w && seq_le(32'(head_seq), 32'(purge_seq_q), SEQ_W)) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else if (replay_q && !empty_w) begin
               state_d  = REPLAY;
               replay_d = 1'b0;
               rp_d     = rd_ptr_q;
               beat_d   = '0;
            end else begin
               state_d  = IDLE;
               replay_d = 1'b0;
            end
         end

         REPLAY: begin
            if (busy_n) begin
               dout_d = rd_beats[beat_sel];
               vld_d  = 1'b1;
               sop_d  = (beat_q == '0);
               eop_d  = (beat_q == LAST_BEAT);
               if (beat_q == LAST_BEAT) begin
                  beat_d = '0;
                  rp_d   = rp_nxt;
                  if (rp_nxt == wr_ptr_q) begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_d = beat_q + BEAT_ONE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; asynchronous reset returns everything to idle/empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rp_q        <= '0;
         beat_q      <= '0;
         replay_q    <= 1'b0;
         pend_q      <= NONE_CODE;
         pend_seq_q  <= '0;
         purge_seq_q <= '0;
         dout_q      <= '0;
         vld_q       <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rp_q        <= rp_d;
         beat_q      <= beat_d;
         replay_q    <= replay_d;
         pend_q      <= pend_d;
         pend_seq_q  <= pend_seq_d;
         purge_seq_q <= purge_seq_d;
         dout_q      <= dout_d;
         vld_q       <= vld_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign dout_sop = sop_q;
   assign dout_eop = eop_q;
   assign empty    = empty_w;

`ifdef REPLAY_NUM_EN
   logic       go_replay;
   logic       ack_free;
   logic [1:0] rnum_q, rnum_d;
   logic       retrain_q, retrain_d;

   assign go_replay = (state_d == REPLAY) && (state_q != REPLAY);
   assign ack_free  = (state_q == PURGE) && !replay_q && (rd_ptr_d != rd_ptr_q);

   // Replay counter: counts replay starts, wraps from 3 with a retrain pulse,
   // and is cleared whenever an ACK actually retires an entry.
   always_comb begin
      rnum_d    = rnum_q;
      retrain_d = 1'b0;
      if (go_replay) begin
         retrain_d = (rnum_q == 2'd3);
         rnum_d    = rnum_q + 2'd1;
      end else if (ack_free) begin
         rnum_d = 2'd0;
      end
   end

   // Replay counter and retrain registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rnum_q    <= 2'd0;
         retrain_q <= 1'b0;
      end else begin
         rnum_q    <= rnum_d;
         retrain_q <= retrain_d;
      end
   end

   assign retrain = retrain_q;
`endif

endmodule

// File: tb/tb_replay_buffer_param.sv
// Scoreboard bench for replay_buffer_param: a queue-based reference model
// predicts every replay beat; a monitor pops and compares on dout_vld.
module tb_replay_buffer_param;

   localparam int DIN_W  = 128;
   localparam int DOUT_W = 16;
   localparam int DEPTH  = 8;
   localparam int SEQ_W  = 12;
   localparam int NB     = DIN_W / DOUT_W;

   localparam logic [1:0] C_ACK = 2'b01;
   localparam logic [1:0] C_NAK = 2'b10;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              we;
   logic [DIN_W-1:0]  din;
   logic [SEQ_W-1:0]  seq;
   logic [1:0]        ack_nack;
   logic [SEQ_W-1:0]  ack_seq;
   logic              tim_out;
   logic              busy_n;
   logic              ready;
   logic [DOUT_W-1:0] dout;
   logic              dout_vld;
   logic              dout_sop;
   logic              dout_eop;
   logic              empty;
`ifdef REPLAY_NUM_EN
   logic              retrain;
`endif

   replay_buffer_param #(
      .DIN_W  (DIN_W),
      .DOUT_W (DOUT_W),
      .DEPTH  (DEPTH),
      .SEQ_W  (SEQ_W)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .din      (din),
      .seq      (seq),
      .ack_nack (ack_nack),
      .ack_seq  (ack_seq),
      .tim_out  (tim_out),
      .busy_n   (busy_n),
      .ready    (ready),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_sop (dout_sop),
      .dout_eop (dout_eop),
`ifdef REPLAY_NUM_EN
      .retrain  (retrain),
`endif
      .empty    (empty)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [DIN_W-1:0] din;
   } ent_t;

   typedef struct packed {
      logic [DOUT_W-1:0] d;
      logic              sop;
      logic              eop;
   } beat_t;

   ent_t  mdl[$];
   beat_t exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int beats_seen = 0;
   int rnum_mdl = 0;
   int exp_retrain = 0;
   int obs_retrain = 0;
   int busy_mode = 0;
   logic [DOUT_W-1:0] last_exp_dout = '0;
   logic              last_eop = 1'b1;
   logic              prev_busy = 1'b1;
   logic [SEQ_W-1:0]  next_seq;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: retire every head entry whose seq is within half the
   // sequence space at or before the acknowledged number.
   function automatic void mdl_purge(input logic [SEQ_W-1:0] a, input bit is_ack);
      int freed = 0;
      logic [SEQ_W-1:0] diff;
      while (mdl.size() > 0) begin
         diff = a - mdl[0].seq;
         if (diff < (1 << (SEQ_W - 1))) begin
            void'(mdl.pop_front());
            freed++;
         end else begin
            break;
         end
      end
      if (is_ack && freed > 0) rnum_mdl = 0;
   endfunction

   // Reference model: a replay emits every held TLP, oldest first, MSB slice first.
   function automatic void mdl_replay();
      beat_t bt;
      if (rnum_mdl == 3) begin
         exp_retrain++;
         rnum_mdl = 0;
      end else begin
         rnum_mdl++;
      end
      foreach (mdl[i]) begin
         for (int b = 0; b < NB; b++) begin
            bt.d   = mdl[i].din[DIN_W-1-DOUT_W*b -: DOUT_W];
            bt.sop = (b == 0);
            bt.eop = (b == NB - 1);
            exp_q.push_back(bt);
         end
      end
   endfunction

   function automatic logic [DIN_W-1:0] rand_tlp();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [SEQ_W-1:0] s, input logic [DIN_W-1:0] d);
      ent_t e;
      tick();
      we  = 1'b1;
      seq = s;
      din = d;
      if (mdl.size() < DEPTH) begin
         e.seq = s;
         e.din = d;
         mdl.push_back(e);
      end
      tick();
      we = 1'b0;
   endtask

   task automatic do_cmd(input logic [1:0] code, input logic [SEQ_W-1:0] s);
      tick();
      ack_nack = code;
      ack_seq  = s;
      if (code == C_ACK) begin
         mdl_purge(s, 1'b1);
      end else begin
         mdl_purge(s, 1'b0);
         if (mdl.size() > 0) mdl_replay();
      end
      tick();
      ack_nack = 2'b00;
   endtask

   task automatic do_tmo();
      tick();
      tim_out = 1'b1;
      if (mdl.size() > 0) mdl_replay();
      tick();
      tim_out = 1'b0;
   endtask

   // Wait for all predicted beats, then let any purge finish.
   task automatic settle();
      int c = 0;
      while (exp_q.size() > 0 && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (exp_q.size() > 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (14) @(negedge clk);
`ifdef REPLAY_NUM_EN
      check("retrain_count", obs_retrain, exp_retrain);
`endif
   endtask

   task automatic wait_beats(input int n);
      int target = beats_seen + n;
      int c = 0;
      while (beats_seen < target && c < 500) begin
         @(negedge clk);
         c++;
      end
      if (beats_seen < target) check("wait_beats_timeout", beats_seen, target);
   endtask

   // Busy driver: always ready, random back-pressure, or forced stall.
   initial begin
      busy_n = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (busy_mode)
            0:       busy_n = 1'b1;
            1:       busy_n = ($urandom_range(0, 3) != 0);
            default: busy_n = 1'b0;
         endcase
      end
   end

   // Monitor: compares each presented beat with the scoreboard head and checks
   // that a mid-TLP stall holds the beat with dout_vld low.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (!prev_busy && !last_eop) begin
               check("stall_vld", dout_vld, 1'b0);
               check("stall_dout", dout, last_exp_dout);
            end
            if (dout_vld) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", {dout, dout_sop, dout_eop}, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", {dout, dout_sop, dout_eop}, {e.d, e.sop, e.eop});
                  last_exp_dout = e.d;
                  last_eop      = e.eop;
                  beats_seen++;
               end
            end
`ifdef REPLAY_NUM_EN
            if (retrain) obs_retrain++;
`endif
         end
         prev_busy = busy_n;
      end
   end

   initial begin
      int c;
      int r;
      logic [SEQ_W-1:0] base;

      reset_n  = 1'b0;
      we       = 1'b0;
      din      = '0;
      seq      = '0;
      ack_nack = 2'b00;
      ack_seq  = '0;
      tim_out  = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_empty", empty, 1'b1);
      check("rst_ready", ready, 1'b1);
      check("rst_vld", dout_vld, 1'b0);
      check("rst_sop_eop", {dout_sop, dout_eop}, 2'b00);
      check("rst_dout", dout, 0);
`ifdef REPLAY_NUM_EN
      check("rst_retrain", retrain, 1'b0);
`endif
      tick();
      reset_n = 1'b1;

      // Fill to full; the ninth write must be ignored.
      for (int i = 0; i < DEPTH; i++) do_write(SEQ_W'(i), rand_tlp());
      @(negedge clk);
      check("ready_when_full", ready, 1'b0);
      check("empty_after_fill", empty, 1'b0);
      do_write(SEQ_W'(8), rand_tlp());
      @(negedge clk);
      check("ready_still_full", ready, 1'b0);

      // ACK 3 on a full buffer: four purges, then ready once back in IDLE.
      tick();
      ack_nack = C_ACK;
      ack_seq  = SEQ_W'(3);
      mdl_purge(SEQ_W'(3), 1'b1);
      tick();
      ack_nack = 2'b00;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!ready && c < 40);
      check("ack_ready_latency", c, 6);
      settle();

      // Timeout replay of seq 4..7 under random back-pressure.
      busy_mode = 1;
      do_tmo();
      settle();
      busy_mode = 0;

      do_cmd(C_ACK, SEQ_W'(7));
      settle();
      check("empty_after_ack7", empty, 1'b1);

      // NAK 1 with seq 0..3 held: two purges, replay of seq 2,3 with a stall.
      for (int i = 0; i < 4; i++) do_write(SEQ_W'(i), rand_tlp());
      tick();
      ack_nack = C_NAK;
      ack_seq  = SEQ_W'(1);
      mdl_purge(SEQ_W'(1), 1'b0);
      mdl_replay();
      tick();
      ack_nack = 2'b00;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!dout_vld && c < 40);
      check("nak_first_beat_latency", c, 5);
      wait_beats(2);
      busy_mode = 2;
      repeat (3) @(posedge clk);
      #3;
      busy_mode = 0;
      settle();

      do_cmd(C_ACK, SEQ_W'(3));
      settle();
      check("empty_after_ack3", empty, 1'b1);

      // Sequence wrap: 4094, 4095, 0.
      do_write(SEQ_W'(4094), rand_tlp());
      do_write(SEQ_W'(4095), rand_tlp());
      do_write(SEQ_W'(0), rand_tlp());
      do_cmd(C_ACK, SEQ_W'(4095));
      settle();
      check("wrap_one_left", empty, 1'b0);
      do_tmo();
      settle();
      do_cmd(C_ACK, SEQ_W'(0));
      settle();
      check("wrap_empty", empty, 1'b1);

      // Replay counter: clear with a freeing ACK, then four timeouts.
      do_write(SEQ_W'(1), rand_tlp());
      do_write(SEQ_W'(2), rand_tlp());
      do_cmd(C_ACK, SEQ_W'(1));
      settle();
      for (int i = 0; i < 4; i++) begin
         do_tmo();
         settle();
      end
      do_cmd(C_ACK, SEQ_W'(2));
      settle();

      // tim_out ignored and ACK deferred while replaying.
      for (int i = 3; i < 7; i++) do_write(SEQ_W'(i), rand_tlp());
      do_tmo();
      wait_beats(4);
      tick();
      tim_out  = 1'b1;
      ack_nack = C_ACK;
      ack_seq  = SEQ_W'(4);
      mdl_purge(SEQ_W'(4), 1'b1);
      tick();
      tim_out  = 1'b0;
      ack_nack = 2'b00;
      settle();
      do_tmo();
      settle();

      // Randomized traffic against the model.
      next_seq  = SEQ_W'(7);
      busy_mode = 1;
      for (int it = 0; it < 40; it++) begin
         r    = $urandom_range(0, 9);
         base = (mdl.size() > 0) ? mdl[0].seq : next_seq;
         if (r < 5) begin
            if (mdl.size() < DEPTH) begin
               do_write(next_seq, rand_tlp());
               next_seq = next_seq + SEQ_W'(1);
            end else begin
               do_write(next_seq, rand_tlp());
               @(negedge clk);
               check("rand_full_ready", ready, 1'b0);
            end
         end else if (r < 7) begin
            do_cmd(C_ACK, base + SEQ_W'($urandom_range(0, 4)) - SEQ_W'(2));
            settle();
         end else if (r < 8) begin
            do_cmd(C_NAK, base + SEQ_W'($urandom_range(0, 4)) - SEQ_W'(2));
            settle();
         end else begin
            do_tmo();
            settle();
         end
         @(negedge clk);
         check("rand_empty", empty, (mdl.size() == 0));
      end
      busy_mode = 0;

      // Reset in the middle of a replay.
      while (mdl.size() < 2) begin
         do_write(next_seq, rand_tlp());
         next_seq = next_seq + SEQ_W'(1);
      end
      do_tmo();
      wait_beats(5);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      exp_q.delete();
      mdl.delete();
      rnum_mdl      = 0;
      last_exp_dout = '0;
      last_eop      = 1'b1;
      @(negedge clk);
      check("midreset_empty", empty, 1'b1);
      check("midreset_vld", dout_vld, 1'b0);
      check("midreset_ready", ready, 1'b1);
      tick();
      reset_n = 1'b1;

      do_write(SEQ_W'(100), rand_tlp());
      do_write(SEQ_W'(101), rand_tlp());
      do_tmo();
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
